// File: rtl/req_enc_pkg.sv
// Shared sizing and FSM state encoding for the request capture encoder.
package req_enc_pkg;
    localparam int N_REQ  = 8;
    localparam int CODE_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/req_capture_encoder_if.sv
// Grant presentation channel: code/valid held until the consumer acknowledges.
interface req_capture_encoder_if;
    import req_enc_pkg::*;

    logic [CODE_W-1:0] out_code;
    logic              out_valid;
    logic              out_ack;

    modport master (output out_code, output out_valid, input  out_ack);
    modport slave  (input  out_code, input  out_valid, output out_ack);
endinterface

// File: rtl/prio_enc8.sv
// Highest-index priority encoder over the pending vector; purely combinational.
module prio_enc8
    import req_enc_pkg::*;
(
    input  logic [N_REQ-1:0]  pending,
    output logic [CODE_W-1:0] code,
    output logic              any
);
    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending[i]) begin
                code = CODE_W'(i);
            end
        end
    end

    assign any = |pending;
endmodule

// File: rtl/req_capture_encoder.sv
// Captures rising edges on request lines into a sticky pending set and presents
// them one at a time, highest index first; one grant per two cycles at most.
module req_capture_encoder
    import req_enc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    req_capture_encoder_if.master      grant,
    output logic [N_REQ-1:0]           pending,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    logic [N_REQ-1:0]  req_d;
    logic [N_REQ-1:0]  rise;
    logic [N_REQ-1:0]  cap;
    logic [N_REQ-1:0]  clr_mask;
    logic              ovf_evt;
    logic [CODE_W-1:0] prio_code;
    logic              prio_any;
    logic [CODE_W-1:0] code_q;
    logic              valid_q;
    logic              ack_take;
    state_t            state;

    prio_enc8 u_prio (
        .pending (pending),
        .code    (prio_code),
        .any     (prio_any)
    );

    assign rise     = req & ~req_d;
    assign cap      = en ? rise : '0;
    assign ack_take = (state == PRESENT) && grant.out_ack;
    assign clr_mask = ack_take ? (N_REQ'(1) << code_q) : '0;
    // A new edge on a bit that is being acked this cycle is a fresh event, not a loss.
    assign ovf_evt  = |(cap & pending & ~clr_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            req_d    <= req;
            pending  <= (pending & ~clr_mask) | cap;
            overflow <= ovf_evt | (overflow & ~clr_ovf);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && prio_any) begin
                        state   <= PRESENT;
                        code_q  <= prio_code;
                        valid_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (grant.out_ack) begin
                        state   <= IDLE;
                        code_q  <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    code_q  <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant.out_code  = code_q;
    assign grant.out_valid = valid_q;
endmodule

// File: tb/tb_req_capture_encoder.sv
// Scenario bench for req_capture_encoder with a queue of expected grant codes.
module tb_req_capture_encoder;
    import req_enc_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr_ovf;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] pending;
    logic             overflow;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned exp_q[$];

    req_capture_encoder_if gif ();

    req_capture_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .grant    (gif),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_valid"}, 32'(gif.out_valid), 0);
        chk({tag, "_code"},  32'(gif.out_code),  0);
    endtask

    // Waits (bounded) for a presented grant, compares it against the scoreboard and acks it.
    task automatic wait_grant(input string tag);
        int n = 0;
        int unsigned exp;
        while (!gif.out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!gif.out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_grant"}, 32'(gif.out_code), 32'hFFFF_FFFF);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, 32'(gif.out_code), exp);
            gif.out_ack = 1'b1;
            tick();
            gif.out_ack = 1'b0;
            chk_idle_out({tag, "_after_ack"});
        end
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        clr_ovf     = 1'b0;
        req         = '0;
        gif.out_ack = 1'b0;
        #12;
        chk("rst_pending", 32'(pending), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk_idle_out("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request: capture, fixed latency, ack clears.
        en  = 1'b1;
        req = 8'h04;
        tick();
        chk("s1_pending", 32'(pending), 32'h04);
        chk("s1_valid_early", 32'(gif.out_valid), 0);
        exp_q.push_back(2);
        tick();
        chk("s1_valid_latency", 32'(gif.out_valid), 1);
        wait_grant("s1_code");
        chk("s1_pending_clr", 32'(pending), 0);
        req = '0;
        tick();

        // Simultaneous edges: both captured, highest index first.
        req = 8'h81;
        exp_q.push_back(7);
        exp_q.push_back(0);
        tick();
        chk("s2_pending", 32'(pending), 32'h81);
        wait_grant("s2_first");
        chk("s2_pending_mid", 32'(pending), 32'h01);
        wait_grant("s2_second");
        chk("s2_pending_end", 32'(pending), 0);
        req = '0;
        tick();

        // Higher-priority edge during presentation does not preempt.
        req = 8'h04;
        exp_q.push_back(2);
        exp_q.push_back(6);
        tick();
        tick();
        req = 8'h44;
        tick();
        chk("s3_hold_code", 32'(gif.out_code), 2);
        chk("s3_pending", 32'(pending), 32'h44);
        tick();
        chk("s3_hold_valid", 32'(gif.out_valid), 1);
        wait_grant("s3_first");
        wait_grant("s3_second");
        req = '0;
        tick();

        // Re-edge on a pending bit sets overflow; set beats clr_ovf; clr_ovf clears.
        req = 8'h08;
        tick();
        tick();
        req = '0;
        tick();
        req = 8'h08;
        tick();
        chk("s4_overflow", 32'(overflow), 1);
        chk("s4_pending", 32'(pending), 32'h08);
        req = '0;
        tick();
        req     = 8'h08;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("s4_ovf_set_wins", 32'(overflow), 1);
        exp_q.push_back(3);
        wait_grant("s4_code");
        chk("s4_ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("s4_ovf_cleared", 32'(overflow), 0);
        req = '0;
        tick();

        // Ack and capture on the same bit in one cycle: set wins, no overflow.
        req = 8'h08;
        tick();
        tick();
        chk("s5_code", 32'(gif.out_code), 3);
        req = '0;
        tick();
        req         = 8'h08;
        gif.out_ack = 1'b1;
        tick();
        gif.out_ack = 1'b0;
        chk("s5_pending_kept", 32'(pending), 32'h08);
        chk("s5_no_overflow", 32'(overflow), 0);
        chk("s5_valid_drop", 32'(gif.out_valid), 0);
        exp_q.push_back(3);
        wait_grant("s5_regrant");
        req = '0;
        tick();

        // Disabled: edges ignored; enabling later with lines high captures nothing.
        en = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req = N_REQ'(1) << i;
            tick();
            chk("s6_pending_off", 32'(pending), 0);
            chk("s6_valid_off", 32'(gif.out_valid), 0);
        end
        en = 1'b1;
        tick();
        tick();
        chk("s6_pending_on", 32'(pending), 0);
        chk("s6_valid_on", 32'(gif.out_valid), 0);
        gif.out_ack = 1'b1;
        tick();
        gif.out_ack = 1'b0;
        chk_idle_out("s6_ack_idle");
        req = '0;
        tick();

        // Reset mid-presentation, then recapture of a line held high through release.
        req = 8'h20;
        tick();
        tick();
        chk("s7_valid_pre", 32'(gif.out_valid), 1);
        chk("s7_code_pre", 32'(gif.out_code), 5);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_out("s7_async");
        chk("s7_async_pending", 32'(pending), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("s7_recapture", 32'(pending), 32'h20);
        exp_q.push_back(5);
        tick();
        chk("s7_valid_latency", 32'(gif.out_valid), 1);
        wait_grant("s7_code");
        req = '0;
        tick();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
